frame_bank_ctrl: RTL
====================

Name: frame_bank_ctrl

Overview:
- Parametrised N-bank frame-buffer sequencer; successor to the fixed two-bank read_bank1/read_bank2 mode control.
- Requests the SPI data path to fill free banks and selects which bank the VGA path displays.
- Holds each bank for a programmable number of VGA frames and stalls tear-free on underrun.
- Sits between the data-acquisition FSM (start_req / video_data_ready) and video_top (read-bank select, VGA_en).

Parameters:
- NUM_BANKS, 2: number of video RAM banks, 2..8.
- PREFILL_BANKS, 1: banks that must be full before playback starts, 1..NUM_BANKS.
- FRAME_REPEAT, 2: VGA frames each bank is shown (2 gives 30 fps content on 60 Hz), 1..15.
- BANK_W, derived: $clog2(NUM_BANKS); localparam, not overridable.

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-high.
- init  in  1  level from the debounced key; rising edge starts or restarts playback.
- wr_done  in  1  one-cycle pulse: writer finished filling bank wr_bank.
- frame_done  in  1  one-cycle pulse at VGA end-of-frame (vsync start).
- start_req  out  1  one-cycle pulse: begin filling bank wr_bank.
- wr_bank  out  BANK_W  bank the writer targets.
- rd_bank_onehot  out  NUM_BANKS  bank being displayed; all-zero when not playing.
- VGA_en  out  1  high in PLAY and STALL.
- pause_en  out  1  high in STALL.
- state_dbg  out  2  encoded FSM state, for LEDR.
- underrun_cnt  out  16  underrun statistics; see Optional Feature.

Behaviour:
- Reset: state IDLE; wr_ptr, rd_ptr, fill_cnt, rep_cnt, fill_busy all 0; every output 0.
- fill_cnt counts full banks, including the displayed one. Width is clog2(NUM_BANKS+1). It never exceeds NUM_BANKS and never underflows.
- Pointers wrap modulo NUM_BANKS, so NUM_BANKS-1 wraps to 0. NUM_BANKS need not be a power of two.
- Edge detect: init_rise = init & ~init_q, with init_q registered.
- start_req fires when all hold: state != IDLE, !fill_busy, fill_cnt < NUM_BANKS, and no wr_done this cycle.
  - It sets fill_busy.
  - wr_bank = wr_ptr. It is registered and stable from start_req until wr_done.
- wr_done:
  - Clears fill_busy, increments fill_cnt and advances wr_ptr.
  - Ignored when fill_busy = 0 (spurious pulse); no state change.
- Release: rd_ptr advances, fill_cnt decrements and rep_cnt clears. A release that coincides with an accepted wr_done leaves fill_cnt unchanged.
- FSM states:
  - IDLE (0): outputs low. init_rise goes to PREFILL.
  - PREFILL (1): fill_cnt >= PREFILL_BANKS goes to PLAY on the next cycle; rd_bank_onehot becomes 1<<rd_ptr in that same cycle.
  - PLAY (2): on frame_done:
    - if rep_cnt < FRAME_REPEAT-1, rep_cnt increments;
    - else if fill_cnt >= 2, release;
    - else go to STALL; rep_cnt holds and rd_ptr is unchanged.
  - STALL (3): the current bank is re-displayed. On frame_done with fill_cnt >= 2: release and return to PLAY. Otherwise stay in STALL.
- Bank switches happen only in the cycle of frame_done. rd_bank_onehot changes one cycle after that frame_done, which guarantees tear-free switching.
- The writer never targets the displayed bank. fill_cnt < NUM_BANKS implies wr_ptr != rd_ptr whenever the displayed bank is held.
- init_rise in PREFILL, PLAY or STALL flushes:
  - all counters and pointers go to 0 and fill_busy clears;
  - state goes to PREFILL;
  - wr_done arriving in the flush cycle is discarded.
- An asynchronous reset mid-fill returns to IDLE. The writer is reset by the same signal.
- Latency: start_req comes 1 cycle after the enabling condition.

Optional Feature:
- Macro: FRAME_BANK_STATS_EN.
- Defined: underrun_cnt increments on each PLAY-to-STALL transition and saturates at 16'hFFFF. It is cleared by reset and by an init flush.
- Undefined: underrun_cnt is tied to 0 and no counter logic is inferred. The port list is identical in both builds.

Decomposition:
- Package frame_bank_pkg holds:
  - typedef enum logic [1:0] {IDLE, PREFILL, PLAY, STALL} bank_state_t;
  - the constant MAX_BANKS = 8;
  - the function bank_inc(ptr, n), giving the modulo-n increment.
- One natural sub-module: bank_ring_ptr, a BANK_W-wide modulo-N pointer with inc and clr inputs. It is instantiated twice, for wr_ptr and rd_ptr.

Test Plan (NUM_BANKS=3, PREFILL_BANKS=2, FRAME_REPEAT=2):
- Reset, then init pulse → start_req with wr_bank=0. wr_done after 10 cycles → start_req with wr_bank=1. Second wr_done → PLAY, rd_bank_onehot=3'b001, VGA_en=1.
- PLAY with 3 banks full, 4 frame_done pulses → rd_bank_onehot goes 001, 001, 010, 010, 100; each change lands 1 cycle after frame_done.
- Writer withheld (fill_cnt=1) at the second frame_done → STALL, pause_en=1, bank unchanged, underrun_cnt=1 (STATS_EN). Then wr_done followed by frame_done → PLAY, next bank shown.
- wr_done and a releasing frame_done in the same cycle → fill_cnt unchanged, rd_ptr and wr_ptr both advance. Wrap from 2 to 0 checked.
- Full condition: fill_cnt=3 → no start_req until a release. Spurious wr_done with fill_busy=0 → no change.
- init pulse mid-PLAY → PREFILL, rd_bank_onehot=0, wr_bank=0, next start_req on the following cycle. Asynchronous reset mid-STALL → all outputs 0 immediately.

Source files
------------

// File: rtl/frame_bank_pkg.sv
// Shared types and helpers for the N-bank frame-buffer sequencer.
package frame_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        PLAY    = 2'd2,
        STALL   = 2'd3
    } bank_state_t;

    localparam int MAX_BANKS = 8;
    localparam int MAX_PTR_W = $clog2(MAX_BANKS);

    // Modulo-n increment; n need not be a power of two.
    function automatic logic [MAX_PTR_W-1:0] bank_inc(input logic [MAX_PTR_W-1:0] ptr,
                                                      input int n);
        logic [MAX_PTR_W-1:0] nxt;
        if (int'(ptr) >= n - 1) nxt = '0;
        else                    nxt = ptr + MAX_PTR_W'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/bank_ring_ptr.sv
// Modulo-N ring pointer with synchronous clear and increment.
module bank_ring_ptr
    import frame_bank_pkg::*;
#(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    logic [MAX_PTR_W-1:0] ptr_ext;

    assign ptr_ext = MAX_PTR_W'(ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= W'(bank_inc(ptr_ext, N));
    end

endmodule

// File: rtl/frame_bank_ctrl.sv
// N-bank frame-buffer sequencer: schedules bank fills and tear-free display switching.
// Optional underrun statistics are built when FRAME_BANK_STATS_EN is defined.
module frame_bank_ctrl
    import frame_bank_pkg::*;
#(
    parameter int  NUM_BANKS     = 2,
    parameter int  PREFILL_BANKS = 1,
    parameter int  FRAME_REPEAT  = 2,
    localparam int BANK_W        = $clog2(NUM_BANKS)
) (
    input  logic                 CLK_40,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 wr_done,
    input  logic                 frame_done,
    output logic                 start_req,
    output logic [BANK_W-1:0]    wr_bank,
    output logic [NUM_BANKS-1:0] rd_bank_onehot,
    output logic                 VGA_en,
    output logic                 pause_en,
    output logic [1:0]           state_dbg,
    output logic [15:0]          underrun_cnt
);

    localparam int                 CNT_W       = $clog2(NUM_BANKS + 1);
    localparam logic [CNT_W-1:0]   ONE_CNT     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   TWO_CNT     = CNT_W'(2);
    localparam logic [CNT_W-1:0]   FULL_CNT    = CNT_W'(NUM_BANKS);
    localparam logic [CNT_W-1:0]   PREFILL_CNT = CNT_W'(PREFILL_BANKS);
    localparam logic [3:0]         REP_LAST    = 4'(FRAME_REPEAT - 1);
    localparam logic [NUM_BANKS-1:0] BANK0_HOT = NUM_BANKS'(1);

    bank_state_t       state, next_state;
    logic              init_q, init_rise, flush;
    logic [CNT_W-1:0]  fill_cnt;
    logic [3:0]        rep_cnt;
    logic              fill_busy;
    logic              rel_bank, rep_inc;
    logic              wr_accept, start_cond;
    logic [BANK_W-1:0] wr_ptr, rd_ptr;

    assign init_rise = init & ~init_q;

    // Writer handshake: start_req is a one-cycle request for bank wr_bank; the writer
    // answers with a one-cycle wr_done, and only one fill is ever outstanding (fill_busy).
    assign wr_accept  = wr_done & fill_busy & ~flush;
    assign start_cond = (state != IDLE) & ~fill_busy & (fill_cnt < FULL_CNT)
                        & ~wr_done & ~flush;

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        rel_bank   = 1'b0;
        rep_inc    = 1'b0;
        flush      = init_rise & (state != IDLE);
        case (state)
            IDLE: begin
                if (init_rise) next_state = PREFILL;
            end
            PREFILL: begin
                if (fill_cnt >= PREFILL_CNT) next_state = PLAY;
            end
            PLAY: begin
                if (frame_done) begin
                    if (rep_cnt < REP_LAST)      rep_inc    = 1'b1;
                    else if (fill_cnt >= TWO_CNT) rel_bank   = 1'b1;
                    else                          next_state = STALL;
                end
            end
            STALL: begin
                if (frame_done && fill_cnt >= TWO_CNT) begin
                    rel_bank   = 1'b1;
                    next_state = PLAY;
                end
            end
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = PREFILL;
            rel_bank   = 1'b0;
            rep_inc    = 1'b0;
        end
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            init_q    <= 1'b0;
            start_req <= 1'b0;
            wr_bank   <= '0;
            fill_cnt  <= '0;
            rep_cnt   <= '0;
            fill_busy <= 1'b0;
        end else begin
            init_q    <= init;
            start_req <= start_cond;
            if (flush) begin
                wr_bank   <= '0;
                fill_cnt  <= '0;
                rep_cnt   <= '0;
                fill_busy <= 1'b0;
            end else begin
                if (start_cond) begin
                    fill_busy <= 1'b1;
                    wr_bank   <= wr_ptr;
                end else if (wr_accept) begin
                    fill_busy <= 1'b0;
                end
                // A fill completing in the release cycle cancels the decrement.
                if (wr_accept && !rel_bank)      fill_cnt <= fill_cnt + ONE_CNT;
                else if (rel_bank && !wr_accept) fill_cnt <= fill_cnt - ONE_CNT;
                if (rel_bank)     rep_cnt <= '0;
                else if (rep_inc) rep_cnt <= rep_cnt + 4'd1;
            end
        end
    end

    bank_ring_ptr #(.N(NUM_BANKS), .W(BANK_W)) u_wr_ptr (
        .clk (CLK_40),
        .rst (reset),
        .inc (wr_accept),
        .clr (flush),
        .ptr (wr_ptr)
    );

    bank_ring_ptr #(.N(NUM_BANKS), .W(BANK_W)) u_rd_ptr (
        .clk (CLK_40),
        .rst (reset),
        .inc (rel_bank),
        .clr (flush),
        .ptr (rd_ptr)
    );

    // Display select is decoded from registers, so it moves only on the edge after frame_done.
    assign rd_bank_onehot = (state == PLAY || state == STALL) ? (BANK0_HOT << rd_ptr) : '0;
    assign VGA_en         = (state == PLAY) || (state == STALL);
    assign pause_en       = (state == STALL);
    assign state_dbg      = state;

`ifdef FRAME_BANK_STATS_EN
    logic [15:0] underrun_q;
    logic        to_stall;

    assign to_stall = (state == PLAY) && (next_state == STALL);

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset)                                   underrun_q <= '0;
        else if (flush)                              underrun_q <= '0;
        else if (to_stall && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule
